fetch_redirect_ctrl: RTL and testbench

//  Next-PC sequencer for the FETCH stage.
//  - Picks each cycle between PC+4 and the branch predictor target.
//  - Keeps a FIFO of in-flight branch predictions from DECODE until EXEC resolves them.
//  - On a mispredict: redirects fetch to the correct PC and flushes the front end.
//  - Keeps saturating prediction and mispredict counters for performance monitoring.

---
 rtl/fetch_redirect_ctrl.sv | 149 ++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Fetch next-PC sequencer: PC+4 / predicted-target selection, in-flight branch
// queue, mispredict redirect with front-end flush, and saturating perf counters.
module fetch_redirect_ctrl #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          FLUSH_CYC = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        f_predict_valid_i,
    input  logic [31:0] f_predict_addr_i,
    input  logic [31:0] d_pc_i,
    input  logic        d_is_branch_i,
    input  logic        x_resolve_i,
    input  logic        x_taken_i,
    input  logic [31:0] x_target_i,
    output logic [31:0] f_pc_o,
    output logic        f_valid_o,
    output logic        flush_o,
    output logic        bp_stall_o,
    output logic        mispredict_o,
    output logic [15:0] pred_cnt_o,
    output logic [15:0] miss_cnt_o,
    output logic        q_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FC_W  = $clog2(FLUSH_CYC + 1);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [0:0]      state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [31:0]     pc_q, pc_d;
    logic            flush_q, misp_q, qerr_q, qerr_d;
    logic [15:0]     pred_q, pred_d, miss_q, miss_d;
    logic            d_pt_q;
    logic [31:0]     d_tgt_q;
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0]  cnt_q, cnt_d;

    logic            q_pt_q   [DEPTH];
    logic [31:0]     q_tgt_q  [DEPTH];
    logic [31:0]     q_fall_q [DEPTH];

    logic        empty, full, pop_ok, push_req, push_ok, mis;
    logic        head_pt;
    logic [31:0] head_tgt, head_fall, redirect_pc;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
    assign head_pt   = q_pt_q[rd_q];
    assign head_tgt  = q_tgt_q[rd_q];
    assign head_fall = q_fall_q[rd_q];

    assign pop_ok   = x_resolve_i & ~empty;
    assign mis      = pop_ok & ((head_pt != x_taken_i) |
                                (x_taken_i & head_pt & (head_tgt != x_target_i)));
    assign redirect_pc = x_taken_i ? x_target_i : head_fall;
    assign push_req = d_is_branch_i & (state_q == S_RUN);
    // A correct pop frees a slot in the same cycle, so a full queue can still accept.
    assign push_ok  = push_req & (~full | pop_ok) & ~mis;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        if (mis) begin
            state_d = S_FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYC - 1);
            pc_d    = redirect_pc;
        end else if (state_q == S_FLUSH) begin
            if (fcnt_q == '0) state_d = S_RUN;
            else              fcnt_d  = fcnt_q - FC_W'(1);
        end else if (!stall_i) begin
            pc_d = f_predict_valid_i ? f_predict_addr_i : pc_q + 32'd4;
        end
    end

    always_comb begin
        rd_d  = rd_q + PTR_W'(pop_ok);
        wr_d  = wr_q + PTR_W'(push_ok);
        cnt_d = cnt_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        if (mis) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
        pred_d = pop_ok ? sat_inc(pred_q) : pred_q;
        miss_d = mis ? sat_inc(miss_q) : miss_q;
        qerr_d = qerr_q | (x_resolve_i & empty) | (push_req & full & ~pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RUN;
            fcnt_q  <= '0;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            misp_q  <= 1'b0;
            qerr_q  <= 1'b0;
            pred_q  <= '0;
            miss_q  <= '0;
            d_pt_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
            flush_q <= mis;
            misp_q  <= mis;
            qerr_q  <= qerr_d;
            pred_q  <= pred_d;
            miss_q  <= miss_d;
            if (!stall_i) d_pt_q <= f_predict_valid_i;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload storage is only read behind a valid count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (!stall_i) d_tgt_q <= f_predict_addr_i;
        if (push_ok) begin
            q_pt_q[wr_q]   <= d_pt_q;
            q_tgt_q[wr_q]  <= d_tgt_q;
            q_fall_q[wr_q] <= d_pc_i + 32'd4;
        end
    end

    assign f_pc_o       = pc_q;
    assign f_valid_o    = (state_q == S_RUN);
    assign flush_o      = flush_q;
    assign mispredict_o = misp_q;
    assign bp_stall_o   = full & d_is_branch_i;
    assign pred_cnt_o   = pred_q;
    assign miss_cnt_o   = miss_q;
    assign q_err_o      = qerr_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios with literal expectations,
// then random traffic against a queue-based behavioural model.
module tb_fetch_redirect_ctrl;

    localparam int          DEPTH     = 4;
    localparam int          FLUSH_CYC = 2;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, f_predict_valid, d_is_branch, x_resolve, x_taken;
    logic [31:0] f_predict_addr, d_pc, x_target;
    logic [31:0] f_pc;
    logic        f_valid, flush, bp_stall, mispredict, q_err;
    logic [15:0] pred_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
        .f_predict_valid_i(f_predict_valid), .f_predict_addr_i(f_predict_addr),
        .d_pc_i(d_pc), .d_is_branch_i(d_is_branch),
        .x_resolve_i(x_resolve), .x_taken_i(x_taken), .x_target_i(x_target),
        .f_pc_o(f_pc), .f_valid_o(f_valid), .flush_o(flush), .bp_stall_o(bp_stall),
        .mispredict_o(mispredict), .pred_cnt_o(pred_cnt), .miss_cnt_o(miss_cnt),
        .q_err_o(q_err)
    );

    typedef struct {
        bit          pt;
        logic [31:0] tgt;
        logic [31:0] fall;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_dtgt;
    int          m_left, m_pred, m_miss;
    bit          m_dpt, m_qerr, m_flush, m_misp;

    task automatic model_reset();
        mq.delete();
        m_pc = RESET_PC; m_dtgt = '0; m_left = 0; m_pred = 0; m_miss = 0;
        m_dpt = 0; m_qerr = 0; m_flush = 0; m_misp = 0;
    endtask

    task automatic model_step();
        bit          run = (m_left == 0);
        bit          popped = 0;
        bit          mis = 0;
        logic [31:0] redir = '0;
        ent_t        h;
        if (x_resolve) begin
            if (mq.size() == 0) m_qerr = 1;
            else begin
                h = mq[0];
                popped = 1;
                if (m_pred < 65535) m_pred++;
                mis = (h.pt != x_taken) || (x_taken && h.tgt != x_target);
                redir = x_taken ? x_target : h.fall;
                if (mis && m_miss < 65535) m_miss++;
            end
        end
        if (d_is_branch && run) begin
            if (mq.size() == DEPTH && !popped) m_qerr = 1;
            else if (!mis) mq.push_back('{m_dpt, m_dtgt, d_pc + 32'd4});
        end
        if (popped) h = mq.pop_front();
        if (mis) begin
            mq.delete();
            m_pc = redir;
            m_left = FLUSH_CYC;
        end else begin
            if (run && !stall) m_pc = f_predict_valid ? f_predict_addr : m_pc + 32'd4;
            if (m_left > 0) m_left--;
        end
        m_flush = mis;
        m_misp  = mis;
        if (!stall) begin
            m_dpt  = f_predict_valid;
            m_dtgt = f_predict_addr;
        end
    endtask

    task automatic clear_inputs();
        stall = 0; f_predict_valid = 0; f_predict_addr = '0; d_pc = '0;
        d_is_branch = 0; x_resolve = 0; x_taken = 0; x_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        #2;
        total++;
        if ({f_pc, f_valid, flush, bp_stall, mispredict, pred_cnt, miss_cnt, q_err} !==
            {RESET_PC, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: pc=%h vld=%b fl=%b bps=%b mp=%b pc=%0d mc=%0d qe=%b",
                     f_pc, f_valid, flush, bp_stall, mispredict, pred_cnt, miss_cnt, q_err);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({f_pc, f_valid, flush} !== {exp_pc[i], 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL seq_pc[%0d]: got pc=%h vld=%b fl=%b want pc=%h vld=1 fl=0",
                         i, f_pc, f_valid, flush, exp_pc[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1;
        step(); step();
        total++;
        if (f_pc !== 32'h0) begin bad++; $display("FAIL stall_hold: got %h want 0", f_pc); end
        stall = 0;
        step();
        total++;
        if (f_pc !== 32'h4) begin bad++; $display("FAIL stall_release: got %h want 4", f_pc); end
    endtask

    task automatic test_predict_taken();
        do_reset();
        step(); step();
        f_predict_valid = 1; f_predict_addr = 32'h40;
        step();
        total++;
        if (f_pc !== 32'h40) begin bad++; $display("FAIL pred_target: got %h want 40", f_pc); end
        f_predict_valid = 0; f_predict_addr = '0; d_pc = 32'h8; d_is_branch = 1;
        step();
        d_is_branch = 0; x_resolve = 1; x_taken = 1; x_target = 32'h40;
        step();
        x_resolve = 0;
        total++;
        if ({flush, mispredict, pred_cnt, miss_cnt, f_pc} !== {1'b0, 1'b0, 16'd1, 16'd0, 32'h48}) begin
            bad++;
            $display("FAIL pred_correct: fl=%b mp=%b pc=%0d mc=%0d fpc=%h want 0 0 1 0 48",
                     flush, mispredict, pred_cnt, miss_cnt, f_pc);
        end
    endtask

    task automatic test_mispredict_nt();
        do_reset();
        d_pc = 32'h10; d_is_branch = 1;
        step();
        d_is_branch = 0; x_resolve = 1; x_taken = 1; x_target = 32'h80;
        step();
        x_resolve = 0;
        total++;
        if ({f_pc, f_valid, flush, mispredict, miss_cnt} !== {32'h80, 1'b0, 1'b1, 1'b1, 16'd1}) begin
            bad++;
            $display("FAIL misp_redirect: pc=%h vld=%b fl=%b mp=%b mc=%0d want 80 0 1 1 1",
                     f_pc, f_valid, flush, mispredict, miss_cnt);
        end
        step();
        total++;
        if ({f_pc, f_valid, flush, mispredict} !== {32'h80, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL misp_flush2: pc=%h vld=%b fl=%b mp=%b want 80 0 0 0",
                     f_pc, f_valid, flush, mispredict);
        end
        step();
        total++;
        if ({f_pc, f_valid} !== {32'h80, 1'b1}) begin
            bad++;
            $display("FAIL misp_resume: pc=%h vld=%b want 80 1", f_pc, f_valid);
        end
        step();
        total++;
        if (f_pc !== 32'h84) begin bad++; $display("FAIL misp_advance: got %h want 84", f_pc); end
    endtask

    task automatic test_wrong_target();
        do_reset();
        f_predict_valid = 1; f_predict_addr = 32'h40;
        step();
        f_predict_valid = 0; d_pc = 32'h30; d_is_branch = 1;
        step();
        d_is_branch = 0; x_resolve = 1; x_taken = 1; x_target = 32'h44;
        step();
        x_resolve = 0;
        total++;
        if ({f_pc, mispredict} !== {32'h44, 1'b1}) begin
            bad++;
            $display("FAIL wrong_target: pc=%h mp=%b want 44 1", f_pc, mispredict);
        end
        step(); step();
        f_predict_valid = 1; f_predict_addr = 32'h40;
        step();
        f_predict_valid = 0; d_pc = 32'h20; d_is_branch = 1;
        step();
        d_is_branch = 0; x_resolve = 1; x_taken = 0; x_target = 32'h0;
        step();
        x_resolve = 0;
        total++;
        if ({f_pc, mispredict, miss_cnt} !== {32'h24, 1'b1, 16'd2}) begin
            bad++;
            $display("FAIL not_taken_fall: pc=%h mp=%b mc=%0d want 24 1 2", f_pc, mispredict, miss_cnt);
        end
        step(); step();
    endtask

    task automatic test_queue_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d_pc = 32'h100 + 32'(i * 4); d_is_branch = 1;
            #1;
            total++;
            if (bp_stall !== 1'b0) begin bad++; $display("FAIL fill_bp_stall[%0d]: got %b want 0", i, bp_stall); end
            step();
        end
        #1;
        total++;
        if (bp_stall !== 1'b1) begin bad++; $display("FAIL full_bp_stall: got %b want 1", bp_stall); end
        step();
        total++;
        if (q_err !== 1'b1) begin bad++; $display("FAIL full_q_err: got %b want 1", q_err); end
        x_resolve = 1; x_taken = 0;
        step();
        x_resolve = 0;
        #1;
        total++;
        if ({bp_stall, mispredict, pred_cnt} !== {1'b1, 1'b0, 16'd1}) begin
            bad++;
            $display("FAIL push_pop_full: bps=%b mp=%b pc=%0d want 1 0 1", bp_stall, mispredict, pred_cnt);
        end
        d_is_branch = 0; x_resolve = 1;
        for (int i = 0; i < 4; i++) step();
        step();
        x_resolve = 0;
        total++;
        if ({pred_cnt, miss_cnt, q_err} !== {16'd5, 16'd0, 1'b1}) begin
            bad++;
            $display("FAIL drain_counts: pc=%0d mc=%0d qe=%b want 5 0 1", pred_cnt, miss_cnt, q_err);
        end
    endtask

    task automatic test_empty_resolve();
        do_reset();
        x_resolve = 1; x_taken = 1; x_target = 32'h80;
        step();
        x_resolve = 0;
        total++;
        if ({q_err, pred_cnt, miss_cnt, flush, f_pc} !== {1'b1, 16'd0, 16'd0, 1'b0, 32'h4}) begin
            bad++;
            $display("FAIL empty_resolve: qe=%b pc=%0d mc=%0d fl=%b fpc=%h want 1 0 0 0 4",
                     q_err, pred_cnt, miss_cnt, flush, f_pc);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        d_pc = 32'h10; d_is_branch = 1;
        step();
        d_is_branch = 0; x_resolve = 1; x_taken = 1; x_target = 32'h80;
        step();
        x_resolve = 0;
        #3 rst_n = 0;
        #1;
        total++;
        if ({f_pc, f_valid, flush, mispredict, miss_cnt} !== {RESET_PC, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL reset_mid_flush: pc=%h vld=%b fl=%b mp=%b mc=%0d want 0 1 0 0 0",
                     f_pc, f_valid, flush, mispredict, miss_cnt);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1;
        step();
        total++;
        if ({f_pc, f_valid} !== {32'h4, 1'b1}) begin
            bad++;
            $display("FAIL after_mid_reset: pc=%h vld=%b want 4 1", f_pc, f_valid);
        end
    endtask

    task automatic test_random();
        logic [67:0] got, exp;
        bit          exp_bps;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            stall           = ($urandom_range(0, 4) == 0);
            f_predict_valid = ($urandom_range(0, 2) == 0);
            f_predict_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            d_pc            = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            d_is_branch     = 1'($urandom_range(0, 1));
            x_resolve       = ($urandom_range(0, 2) == 0);
            x_taken         = 1'($urandom_range(0, 1));
            x_target        = $urandom & 32'hFFFF_FFFC;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                x_taken = mq[0].pt;
                if (mq[0].pt) x_target = mq[0].tgt;
            end
            #1;
            exp_bps = (mq.size() == DEPTH) && d_is_branch;
            total++;
            if (bp_stall !== exp_bps) begin
                bad++;
                $display("FAIL rand_bp_stall[%0d]: got %b want %b", i, bp_stall, exp_bps);
            end
            step();
            got = {f_pc, f_valid, flush, mispredict, pred_cnt, miss_cnt, q_err};
            exp = {m_pc, (m_left == 0), m_flush, m_misp, 16'(m_pred), 16'(m_miss), m_qerr};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rand_state[%0d]: got pc=%h vld=%b fl=%b mp=%b pc=%0d mc=%0d qe=%b want %h %b %b %b %0d %0d %b",
                         i, f_pc, f_valid, flush, mispredict, pred_cnt, miss_cnt, q_err,
                         m_pc, (m_left == 0), m_flush, m_misp, m_pred, m_miss, m_qerr);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_predict_taken();
        test_mispredict_nt();
        test_wrong_target();
        test_queue_full();
        test_empty_resolve();
        test_reset_mid_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
